// File: rtl/tile_pkg.sv
// Shared constants and bundles for the tile renderer.
package tile_pkg;

  localparam int TILE_W       = 8;
  localparam int TILE_H       = 8;
  localparam int PIPE_LATENCY = 3;
  localparam int IDX_LSB      = 0;
  localparam int FG_LSB       = 8;
  localparam int BG_LSB       = 12;
  localparam int COLOR_W      = 4;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

endpackage

// File: rtl/tile_renderer_sync_delay.sv
// Fixed-depth shift register with synchronous reset.
module sync_delay #(
  parameter int W     = 3,
  parameter int DEPTH = 3
) (
  input  logic         dot_clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_pre
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge dot_clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  // q_pre is the tap one stage before the output
  assign q     = sr[DEPTH-1];
  assign q_pre = sr[DEPTH-2];

endmodule

// File: rtl/tile_renderer.sv
// Tile-map renderer: col/row -> 4-bit colour index through
// map RAM, pattern RAM and output register (3-cycle latency).
module tile_renderer
  import tile_pkg::*;
#(
  parameter int HBITS         = 10,
  parameter int VBITS         = 10,
  parameter int MAP_COLS_LOG2 = 7,
  parameter int MAP_ROWS_LOG2 = 6,
  parameter int MAP_AW        = 13,
  parameter int PAT_AW        = 11
) (
  input  logic                       dot_clock,
  input  logic                       reset,
  input  logic [VBITS-1:0]           row,
  input  logic [HBITS-1:0]           col,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       active_in,
  input  logic [MAP_COLS_LOG2+2:0]   scroll_x,
  input  logic [MAP_ROWS_LOG2+2:0]   scroll_y,
  output logic [MAP_AW-1:0]          map_addr,
  input  logic [15:0]                map_data,
  output logic [PAT_AW-1:0]          pat_addr,
  input  logic [7:0]                 pat_data,
  output logic [COLOR_W-1:0]         color,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       active_out
);

  localparam int XW = MAP_COLS_LOG2 + 3;
  localparam int YW = MAP_ROWS_LOG2 + 3;

  logic [XW-1:0] sx, x;
  logic [YW-1:0] sy, y;
  logic          vs_prev;
  logic [2:0]    x1, y1, x2;
  logic [7:0]    attr2;
  logic          pix;
  sync_t         s_in, s2, s3;

  // Scroll shadows only move on a vsync rise
  always_ff @(posedge dot_clock) begin
    if (reset) begin
      vs_prev <= 1'b0;
      sx      <= '0;
      sy      <= '0;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) begin
        sx <= scroll_x;
        sy <= scroll_y;
      end
    end
  end

  assign x        = XW'(col) + sx;
  assign y        = YW'(row) + sy;
  assign map_addr = {y[YW-1:3], x[XW-1:3]};
  assign pat_addr = {map_data[IDX_LSB +: 8], y1};

  always_ff @(posedge dot_clock) begin
    if (reset) begin
      x1    <= '0;
      y1    <= '0;
      x2    <= '0;
      attr2 <= '0;
    end else begin
      x1    <= x[2:0];
      y1    <= y[2:0];
      x2    <= x1;
      attr2 <= map_data[FG_LSB +: 8];
    end
  end

  assign s_in = '{hsync: hsync_in, vsync: vsync_in,
                  active: active_in};

  sync_delay #(
    .W     ($bits(sync_t)),
    .DEPTH (PIPE_LATENCY)
  ) u_sync (
    .dot_clock (dot_clock),
    .reset     (reset),
    .d         (s_in),
    .q         (s3),
    .q_pre     (s2)
  );

  // Bit 7 is the leftmost pixel of the pattern byte
  assign pix = pat_data[3'd7 - x2];

  always_ff @(posedge dot_clock) begin
    if (reset)
      color <= '0;
    else if (!s2.active)
      color <= '0;
    else
      color <= pix ? attr2[FG_LSB-8 +: COLOR_W]
                   : attr2[BG_LSB-8 +: COLOR_W];
  end

  assign hsync_out  = s3.hsync;
  assign vsync_out  = s3.vsync;
  assign active_out = s3.active;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed-vector bench for tile_renderer with behavioural
// 1-cycle-latency map and pattern RAMs.
module tb_tile_renderer;

  logic        dot_clock = 1'b0;
  logic        reset;
  logic [9:0]  row, col;
  logic        hsync_in, vsync_in, active_in;
  logic [9:0]  scroll_x;
  logic [8:0]  scroll_y;
  logic [12:0] map_addr;
  logic [15:0] map_data;
  logic [10:0] pat_addr;
  logic [7:0]  pat_data;
  logic [3:0]  color;
  logic        hsync_out, vsync_out, active_out;

  logic [15:0] map_mem [8192];
  logic [7:0]  pat_mem [2048];

  int checks = 0;
  int failures = 0;

  always #5 dot_clock = ~dot_clock;

  always @(posedge dot_clock) begin
    map_data <= map_mem[map_addr];
    pat_data <= pat_mem[pat_addr];
  end

  tile_renderer dut (
    .dot_clock  (dot_clock),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .active_in  (active_in),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .map_addr   (map_addr),
    .map_data   (map_data),
    .pat_addr   (pat_addr),
    .pat_data   (pat_data),
    .color      (color),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .active_out (active_out)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [9:0] r, input logic [9:0] c,
                       input logic hs, input logic vs,
                       input logic act);
    row = r; col = c;
    hsync_in = hs; vsync_in = vs; active_in = act;
  endtask

  typedef struct {
    logic [9:0]  row;
    logic [9:0]  col;
    logic        hs;
    logic        vs;
    logic        act;
    logic [12:0] ma;
    logic [10:0] pa;
    logic [3:0]  clr;
  } vec_t;

  vec_t tbl [13];

  typedef struct {
    logic hs;
    logic vs;
    logic act;
  } hist_t;

  hist_t hist [$];

  initial begin
    for (int i = 0; i < 8192; i++) map_mem[i] = 16'h0000;
    for (int i = 0; i < 2048; i++) pat_mem[i] = 8'h00;
    map_mem[0]   = 16'h2A05;
    map_mem[1]   = 16'h3B07;
    map_mem[127] = 16'h4C09;
    map_mem[128] = 16'h5D0A;
    pat_mem[11'h028] = 8'h80;
    pat_mem[11'h038] = 8'h01;
    pat_mem[11'h048] = 8'hFF;
    pat_mem[11'h051] = 8'h80;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{10'd0, 10'(i), 1'b0, 1'b0, 1'b1, 13'd0,
                 11'h028, (i == 0) ? 4'hA : 4'h2};
    tbl[8]  = '{10'd0, 10'd8,  1'b0, 1'b0, 1'b1, 13'd1,   11'h038, 4'h3};
    tbl[9]  = '{10'd0, 10'd15, 1'b0, 1'b0, 1'b1, 13'd1,   11'h038, 4'hB};
    tbl[10] = '{10'd0, 10'd0,  1'b0, 1'b0, 1'b0, 13'd0,   11'h028, 4'h0};
    tbl[11] = '{10'd9, 10'd0,  1'b1, 1'b0, 1'b1, 13'd128, 11'h051, 4'hD};
    tbl[12] = '{10'd0, 10'd1,  1'b1, 1'b1, 1'b1, 13'd0,   11'h028, 4'h2};

    // Reset with random stimulus: outputs must stay zero
    reset = 1'b1;
    scroll_x = '0; scroll_y = '0;
    drive(0, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      @(negedge dot_clock);
      drive(10'($urandom), 10'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      scroll_x = 10'($urandom);
      scroll_y = 9'($urandom);
      #1;
      chk("reset_color", 32'(color), 0);
      chk("reset_syncs", {hsync_out, vsync_out, active_out}, 0);
    end

    // After reset: shadows zero, first colour at cycle 3
    @(negedge dot_clock);
    reset = 1'b0;
    scroll_x = 10'd37; scroll_y = 9'd5;
    drive(0, 0, 0, 0, 1);
    #1;
    chk("post_reset_map_addr", 32'(map_addr), 0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge dot_clock);
      #1;
      chk("post_reset_color", 32'(color), (n == 3) ? 32'hA : 0);
      chk("post_reset_active", 32'(active_out), (n == 3) ? 1 : 0);
    end
    scroll_x = '0; scroll_y = '0;

    // Table-driven lookups
    for (int i = 0; i < 16; i++) begin
      @(negedge dot_clock);
      if (i < 13)
        drive(tbl[i].row, tbl[i].col, tbl[i].hs, tbl[i].vs, tbl[i].act);
      else
        drive(0, 0, 0, 0, 0);
      #1;
      if (i < 13)
        chk($sformatf("map_addr[%0d]", i), 32'(map_addr), 32'(tbl[i].ma));
      if (i >= 1 && i <= 13)
        chk($sformatf("pat_addr[%0d]", i-1), 32'(pat_addr),
            32'(tbl[i-1].pa));
      if (i >= 3) begin
        chk($sformatf("color[%0d]", i-3), 32'(color), 32'(tbl[i-3].clr));
        chk($sformatf("syncs[%0d]", i-3),
            {hsync_out, vsync_out, active_out},
            {tbl[i-3].hs, tbl[i-3].vs, tbl[i-3].act});
      end
    end

    // Scroll only latched on vsync rise
    @(negedge dot_clock);
    scroll_x = 10'd8;
    drive(0, 0, 0, 0, 1);
    #1;
    chk("scroll_hold_midframe", 32'(map_addr), 0);
    @(negedge dot_clock);
    drive(0, 0, 0, 1, 1);
    #1;
    chk("scroll_hold_rise_cycle", 32'(map_addr), 0);
    @(negedge dot_clock);
    drive(0, 0, 0, 0, 1);
    #1;
    chk("scroll_after_rise", 32'(map_addr), 1);

    // Horizontal and vertical wrap
    @(negedge dot_clock);
    scroll_x = 10'd1020; scroll_y = 9'd510;
    drive(2, 4, 0, 1, 1);
    @(negedge dot_clock);
    drive(2, 4, 0, 0, 1);
    #1;
    chk("wrap_x0", 32'(map_addr), 0);
    drive(2, 3, 0, 0, 1);
    #1;
    chk("wrap_x1023", 32'(map_addr), 127);
    drive(1, 4, 0, 0, 1);
    #1;
    chk("wrap_y511", 32'(map_addr), 8064);
    drive(1, 3, 0, 0, 1);
    #1;
    chk("wrap_xy", 32'(map_addr), 8191);

    // Sync alignment and blank override on a solid-fg tile
    for (int k = 0; k < 120; k++) begin
      hist_t h;
      logic [6:0] kk;
      kk = 7'(k);
      h.hs = (k >= 10 && k < 106);
      h.vs = kk[3];
      h.act = kk[2];
      @(negedge dot_clock);
      drive(2, 3, h.hs, h.vs, h.act);
      hist.push_back(h);
      #1;
      if (k >= 3) begin
        chk("align_hsync", 32'(hsync_out), 32'(hist[k-3].hs));
        chk("align_vsync", 32'(vsync_out), 32'(hist[k-3].vs));
        chk("align_active", 32'(active_out), 32'(hist[k-3].act));
        chk("blank_color", 32'(color), hist[k-3].act ? 32'hC : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
